// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory master.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Natural alignment check on the low address bits; bytes are never misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = lo[0];
      SIZE_WORD: mis = (lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Lane steering: load extract/extend and sub-word store merge, purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/half (little-endian) and extend it for loads.
  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SIZE_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_load_data = i_rdata;
    endcase
  end

  // Replace only the target lane(s) of the read word with the store data.
  always_comb begin
    o_merge_data = i_rdata;
    case (i_size)
      SIZE_BYTE: begin
        case (i_lane)
          2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          default: o_merge_data[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (i_lane[1]) o_merge_data[31:16] = i_wdata[15:0];
        else           o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Requester side of the data memory port: one load/store in flight, RMW for sub-word stores.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a request; request fields latched on acceptance
// ST_READ  | memory read; captures load result or merged store word
// ST_WRITE | memory write of full or merged word
// ST_RESP  | one-cycle response pulse
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_w_en,
  output logic              o_mem_r_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_din,
  input  logic [31:0]       i_mem_dout
);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_addr_fix;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

  assign w_accept    = i_req_valid && (r_state == ST_IDLE);
  assign w_req_err   = (i_req_size == SIZE_ILL) ||
                       (ERR_ON_MISALIGN && is_misaligned(i_req_size, i_req_addr[1:0]));
  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // With misalign errors disabled, silently clear the offending low address bits.
  always_comb begin
    w_addr_fix = i_req_addr;
    if (!ERR_ON_MISALIGN) begin
      if (i_req_size == SIZE_HALF)      w_addr_fix[0]   = 1'b0;
      else if (i_req_size == SIZE_WORD) w_addr_fix[1:0] = 2'b00;
    end
  end

  lsu_lane_align u_lane_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_lane       (r_addr[1:0]),
    .i_rdata      (i_mem_dout),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // State register; async reset aborts any transaction before its write edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode and memory/response port drivers.
  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 1'b0;
    o_mem_r_en   = 1'b0;
    o_mem_w_en   = 1'b0;
    o_mem_addr   = '0;
    o_mem_din    = '0;
    o_rsp_valid  = 1'b0;
    o_rsp_err    = 1'b0;
    o_rsp_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_req_err)                               w_next_state = ST_RESP;
          else if (!i_req_we || i_req_size != SIZE_WORD) w_next_state = ST_READ;
          else                                         w_next_state = ST_WRITE;
        end
      end
      ST_READ: begin
        o_mem_r_en   = 1'b1;
        o_mem_addr   = w_word_addr;
        w_next_state = r_we ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        o_mem_w_en   = 1'b1;
        o_mem_addr   = w_word_addr;
        o_mem_din    = r_wdata;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_err    = r_err;
        o_rsp_rdata  = r_rdata;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latch at acceptance; READ folds mem_dout into load result or store word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_we       <= i_req_we;
      r_size     <= i_req_size;
      r_unsigned <= i_req_unsigned;
      r_addr     <= w_addr_fix;
      r_wdata    <= i_req_wdata;
      r_rdata    <= '0;
      r_err      <= w_req_err;
    end else if (r_state == ST_READ) begin
      if (r_we) r_wdata <= w_merge_data;
      else      r_rdata <= w_load_data;
    end
  end

endmodule
